iod_multilane_bit_align: RTL and testbench

//  Parametrised multi-lane successor to the single-lane IOD bit-align trainer. It sweeps the
//  ICB tap delay of each lane in turn and records the widest run of taps with no EARLY/LATE flag.
//  It then programs each lane to the centre of that run. Sits between the RX IOD controllers
//  and the video/MIPI receive path; one shared FSM serves all lanes sequentially.

---
 rtl/iod_bit_align_pkg.sv | 25 ++
 rtl/iod_eye_tracker.sv | 64 ++++++
 rtl/iod_multilane_bit_align.sv | 223 ++++++++++++++++++++++
 tb/tb_iod_multilane_bit_align.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/iod_bit_align_pkg.sv
// Shared types and helpers for the multi-lane IOD bit-align trainer.
package iod_bit_align_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CLR,
      ST_WAIT,
      ST_SAMPLE,
      ST_STEP,
      ST_EVAL,
      ST_APPLY_LOAD,
      ST_APPLY_MOVE,
      ST_APPLY_GAP,
      ST_NEXT,
      ST_DONE
   } align_state_e;

   localparam logic ALGN_DIR_INC = 1'b1;

   function automatic int tap_count(input int width);
      return 1 << width;
   endfunction

endpackage

// File: rtl/iod_eye_tracker.sv
// Tracks the current clean-tap run and the widest run seen so far for the lane being swept.
module iod_eye_tracker #(
   parameter int TAP_CNT_WIDTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     clear_i,
   input  logic                     sample_i,
   input  logic                     clean_i,
   input  logic [TAP_CNT_WIDTH-1:0] tap_i,
   output logic [TAP_CNT_WIDTH-1:0] best_start_o,
   output logic [TAP_CNT_WIDTH-1:0] best_len_o
);

   localparam logic [TAP_CNT_WIDTH-1:0] LEN_MAX = '1;

   logic [TAP_CNT_WIDTH-1:0] run_start_q, run_start_d;
   logic [TAP_CNT_WIDTH-1:0] run_len_q, run_len_d;
   logic [TAP_CNT_WIDTH-1:0] best_start_q, best_start_d;
   logic [TAP_CNT_WIDTH-1:0] best_len_q, best_len_d;

   // Best is refreshed while a run grows, so a run touching the sweep end still counts.
   always_comb begin
      run_start_d  = run_start_q;
      run_len_d    = run_len_q;
      best_start_d = best_start_q;
      best_len_d   = best_len_q;
      if (clear_i) begin
         run_start_d  = '0;
         run_len_d    = '0;
         best_start_d = '0;
         best_len_d   = '0;
      end else if (sample_i) begin
         if (clean_i) begin
            if (run_len_q == '0) run_start_d = tap_i;
            if (run_len_q != LEN_MAX) run_len_d = run_len_q + 1'b1;
            if (run_len_d > best_len_q) begin
               best_len_d   = run_len_d;
               best_start_d = run_start_d;
            end
         end else begin
            run_len_d = '0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         run_start_q  <= '0;
         run_len_q    <= '0;
         best_start_q <= '0;
         best_len_q   <= '0;
      end else begin
         run_start_q  <= run_start_d;
         run_len_q    <= run_len_d;
         best_start_q <= best_start_d;
         best_len_q   <= best_len_d;
      end
   end

   assign best_start_o = best_start_q;
   assign best_len_o   = best_len_q;

endmodule

// File: rtl/iod_multilane_bit_align.sv
// Multi-lane IOD bit-align trainer: one FSM sweeps each lane's tap delay and centres it in the eye.
// Optional EYE_WIDTH output is built when IOD_ALIGN_EYE_WIDTH_EN is defined.
module iod_multilane_bit_align
   import iod_bit_align_pkg::*;
#(
   parameter int NUM_LANES          = 4,
   parameter int TAP_CNT_WIDTH      = 8,
   parameter int TAP_WAIT_CNT_WIDTH = 3,
   parameter int MIN_WINDOW_VALUE   = 10
) (
   input  logic                                SCLK,
   input  logic                                RESETN,
   input  logic                                PLL_LOCK,
   input  logic                                ALGN_RSTRT,
   input  logic                                ALGN_HOLD,
   input  logic                                ALGN_SKIP,
   input  logic [NUM_LANES-1:0]                IOD_EARLY,
   input  logic [NUM_LANES-1:0]                IOD_LATE,
   input  logic [NUM_LANES-1:0]                IOD_OOR,
   output logic [NUM_LANES-1:0]                ALGN_LOAD,
   output logic [NUM_LANES-1:0]                ALGN_MOVE,
   output logic [NUM_LANES-1:0]                ALGN_DIR,
   output logic [NUM_LANES-1:0]                ALGN_CLR_FLGS,
   output logic                                ALGN_START,
   output logic                                ALGN_DONE,
   output logic                                ALGN_ERR,
   output logic [NUM_LANES-1:0]                LANE_ERR,
   output logic                                ALGN_OOR,
   output logic [NUM_LANES*TAP_CNT_WIDTH-1:0]  TAPDLY,
`ifdef IOD_ALIGN_EYE_WIDTH_EN
   output logic [NUM_LANES*TAP_CNT_WIDTH-1:0]  EYE_WIDTH,
`endif
   output logic [3:0]                          DBG_STATE
);

   localparam int W  = TAP_CNT_WIDTH;
   localparam int WW = TAP_WAIT_CNT_WIDTH;
   localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam logic [W-1:0]  TAP_LAST  = W'(tap_count(W) - 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(tap_count(WW) - 1);
   localparam logic [W:0]    MIN_WIN   = (W+1)'(MIN_WINDOW_VALUE);
   localparam logic [LW-1:0] LANE_LAST = LW'(NUM_LANES - 1);

   align_state_e state_q, state_d;
   logic [LW-1:0]          lane_q, lane_d;
   logic [W-1:0]           tap_q, tap_d;
   logic [WW-1:0]          wait_q, wait_d;
   logic [W-1:0]           move_q, move_d;
   logic [W-1:0]           centre_q, centre_d;
   logic [NUM_LANES-1:0]   lane_err_q, lane_err_d;
   logic                   oor_q, oor_d;
   logic [NUM_LANES*W-1:0] tapdly_q, tapdly_d;
   logic                   rstrt_q;
   logic [NUM_LANES-1:0]   lane_oh;
   logic [W-1:0]           best_start, best_len;

   // Restart and PLL loss override HOLD; pulses and state only advance when pulse_en is set.
   logic rstrt_edge, training, pll_abort, pulse_en;
   assign rstrt_edge = ALGN_RSTRT & ~rstrt_q;
   assign training   = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign pll_abort  = training & ~PLL_LOCK;
   assign pulse_en   = ~ALGN_HOLD & ~rstrt_edge & ~pll_abort;

   logic lane_clean, lane_oor;
   assign lane_clean = ~IOD_EARLY[lane_q] & ~IOD_LATE[lane_q];
   assign lane_oor   = IOD_OOR[lane_q];

   iod_eye_tracker #(.TAP_CNT_WIDTH(W)) u_eye (
      .clk_i        (SCLK),
      .rst_ni       (RESETN),
      .clear_i      (pulse_en && state_q == ST_LOAD),
      .sample_i     (pulse_en && state_q == ST_SAMPLE),
      .clean_i      (lane_clean),
      .tap_i        (tap_q),
      .best_start_o (best_start),
      .best_len_o   (best_len)
   );

   always_ff @(posedge SCLK or negedge RESETN) begin
      if (!RESETN) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (rstrt_edge || pll_abort) begin
         state_d = ST_IDLE;
      end else if (!ALGN_HOLD) begin
         unique case (state_q)
            ST_IDLE:       if (ALGN_SKIP) state_d = ST_DONE;
                           else if (PLL_LOCK) state_d = ST_LOAD;
            ST_LOAD:       state_d = ST_CLR;
            ST_CLR:        state_d = ST_WAIT;
            ST_WAIT:       if (wait_q == WAIT_LAST) state_d = ST_SAMPLE;
            ST_SAMPLE:     state_d = (tap_q == TAP_LAST || lane_oor) ? ST_EVAL : ST_STEP;
            ST_STEP:       state_d = ST_CLR;
            ST_EVAL:       state_d = ST_APPLY_LOAD;
            ST_APPLY_LOAD: state_d = (centre_q == '0) ? ST_NEXT : ST_APPLY_MOVE;
            ST_APPLY_MOVE: state_d = (move_q == W'(1)) ? ST_NEXT : ST_APPLY_GAP;
            ST_APPLY_GAP:  state_d = ST_APPLY_MOVE;
            ST_NEXT:       state_d = (lane_q == LANE_LAST) ? ST_DONE : ST_LOAD;
            ST_DONE:       state_d = ST_DONE;
            default:       state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      lane_d     = lane_q;
      tap_d      = tap_q;
      wait_d     = wait_q;
      move_d     = move_q;
      centre_d   = centre_q;
      lane_err_d = lane_err_q;
      oor_d      = oor_q;
      tapdly_d   = tapdly_q;
      if (rstrt_edge || pll_abort) begin
         lane_d     = '0;
         lane_err_d = '0;
         oor_d      = 1'b0;
         tapdly_d   = '0;
      end else if (pulse_en) begin
         unique case (state_q)
            ST_IDLE: begin
               lane_d = '0;
               if (ALGN_SKIP) begin
                  tapdly_d   = '0;
                  lane_err_d = '0;
               end
            end
            ST_LOAD:   tap_d  = '0;
            ST_CLR:    wait_d = '0;
            ST_WAIT:   wait_d = wait_q + 1'b1;
            ST_SAMPLE: if (lane_oor) oor_d = 1'b1;
            ST_STEP:   tap_d  = tap_q + 1'b1;
            ST_EVAL: begin
               if ({1'b0, best_len} < MIN_WIN) begin
                  lane_err_d[lane_q] = 1'b1;
                  centre_d           = '0;
               end else begin
                  centre_d = best_start + (best_len >> 1);
               end
            end
            ST_APPLY_LOAD: move_d = centre_q;
            ST_APPLY_MOVE: move_d = move_q - 1'b1;
            ST_NEXT: begin
               tapdly_d[lane_q*W +: W] = centre_q;
               if (lane_q != LANE_LAST) lane_d = lane_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge SCLK or negedge RESETN) begin
      if (!RESETN) begin
         lane_q     <= '0;
         tap_q      <= '0;
         wait_q     <= '0;
         move_q     <= '0;
         centre_q   <= '0;
         lane_err_q <= '0;
         oor_q      <= 1'b0;
         tapdly_q   <= '0;
         rstrt_q    <= 1'b0;
      end else begin
         lane_q     <= lane_d;
         tap_q      <= tap_d;
         wait_q     <= wait_d;
         move_q     <= move_d;
         centre_q   <= centre_d;
         lane_err_q <= lane_err_d;
         oor_q      <= oor_d;
         tapdly_q   <= tapdly_d;
         rstrt_q    <= ALGN_RSTRT;
      end
   end

`ifdef IOD_ALIGN_EYE_WIDTH_EN
   logic [NUM_LANES*W-1:0] eye_q, eye_d;

   always_comb begin
      eye_d = eye_q;
      if (rstrt_edge || pll_abort)              eye_d = '0;
      else if (pulse_en && state_q == ST_EVAL)  eye_d[lane_q*W +: W] = best_len;
   end

   always_ff @(posedge SCLK or negedge RESETN) begin
      if (!RESETN) eye_q <= '0;
      else         eye_q <= eye_d;
   end

   assign EYE_WIDTH = eye_q;
`else
   // Eye widths are not retained in this build.
`endif

   always_comb begin
      lane_oh         = '0;
      lane_oh[lane_q] = 1'b1;
      ALGN_LOAD       = '0;
      ALGN_MOVE       = '0;
      ALGN_CLR_FLGS   = '0;
      if (pulse_en) begin
         unique case (state_q)
            ST_LOAD, ST_APPLY_LOAD: ALGN_LOAD     = lane_oh;
            ST_CLR:                 ALGN_CLR_FLGS = lane_oh;
            ST_STEP, ST_APPLY_MOVE: ALGN_MOVE     = lane_oh;
            default: ;
         endcase
      end
      ALGN_START = training;
      ALGN_DONE  = (state_q == ST_DONE);
      ALGN_ERR   = |lane_err_q;
      LANE_ERR   = lane_err_q;
      ALGN_OOR   = oor_q;
      TAPDLY     = tapdly_q;
      DBG_STATE  = state_q;
   end

   assign ALGN_DIR = {NUM_LANES{ALGN_DIR_INC}};

endmodule

// File: tb/tb_iod_multilane_bit_align.sv
// Directed bench for iod_multilane_bit_align: a tap-tracking IOD model, a vector table and corner sequences.
module tb_iod_multilane_bit_align;

   localparam int NL = 2;
   localparam int W  = 8;
   localparam int N  = 999;   // window bound that no tap reaches

   logic SCLK = 1'b0;
   logic RESETN = 1'b0;
   logic PLL_LOCK = 1'b0;
   logic ALGN_RSTRT = 1'b0;
   logic ALGN_HOLD = 1'b0;
   logic ALGN_SKIP = 1'b0;
   logic [NL-1:0] IOD_EARLY, IOD_LATE, IOD_OOR;
   logic [NL-1:0] ALGN_LOAD, ALGN_MOVE, ALGN_DIR, ALGN_CLR_FLGS, LANE_ERR;
   logic ALGN_START, ALGN_DONE, ALGN_ERR, ALGN_OOR;
   logic [NL*W-1:0] TAPDLY;
   logic [3:0] dbg_state;
`ifdef IOD_ALIGN_EYE_WIDTH_EN
   logic [NL*W-1:0] eye_width;
`endif

   always #5 SCLK = ~SCLK;

   iod_multilane_bit_align #(
      .NUM_LANES(NL), .TAP_CNT_WIDTH(W), .TAP_WAIT_CNT_WIDTH(2), .MIN_WINDOW_VALUE(10)
   ) dut (
      .SCLK(SCLK), .RESETN(RESETN), .PLL_LOCK(PLL_LOCK), .ALGN_RSTRT(ALGN_RSTRT),
      .ALGN_HOLD(ALGN_HOLD), .ALGN_SKIP(ALGN_SKIP), .IOD_EARLY(IOD_EARLY),
      .IOD_LATE(IOD_LATE), .IOD_OOR(IOD_OOR), .ALGN_LOAD(ALGN_LOAD), .ALGN_MOVE(ALGN_MOVE),
      .ALGN_DIR(ALGN_DIR), .ALGN_CLR_FLGS(ALGN_CLR_FLGS), .ALGN_START(ALGN_START),
      .ALGN_DONE(ALGN_DONE), .ALGN_ERR(ALGN_ERR), .LANE_ERR(LANE_ERR), .ALGN_OOR(ALGN_OOR),
      .TAPDLY(TAPDLY),
`ifdef IOD_ALIGN_EYE_WIDTH_EN
      .EYE_WIDTH(eye_width),
`endif
      .DBG_STATE(dbg_state)
   );

   // IOD model: each lane's tap follows LOAD/MOVE pulses; flags are a function of that tap.
   int lo_a[NL], hi_a[NL], lo_b[NL], hi_b[NL], oor_at[NL];
   int tap_m[NL] = '{0, 0};
   int pulse_total = 0;

   always @(posedge SCLK) begin
      for (int i = 0; i < NL; i++) begin
         if (ALGN_LOAD[i])      tap_m[i] <= 0;
         else if (ALGN_MOVE[i]) tap_m[i] <= tap_m[i] + 1;
      end
      pulse_total <= pulse_total + $countones({ALGN_LOAD, ALGN_MOVE, ALGN_CLR_FLGS});
   end

   always_comb begin
      IOD_EARLY = '0;
      IOD_LATE  = '0;
      IOD_OOR   = '0;
      for (int i = 0; i < NL; i++) begin
         if (!((tap_m[i] >= lo_a[i] && tap_m[i] <= hi_a[i]) ||
               (tap_m[i] >= lo_b[i] && tap_m[i] <= hi_b[i]))) begin
            if (tap_m[i] % 2 == 1) IOD_EARLY[i] = 1'b1;
            else                   IOD_LATE[i]  = 1'b1;
         end
         IOD_OOR[i] = (tap_m[i] == oor_at[i]);
      end
   end

   typedef struct {
      int l0_lo, l0_hi, l0_lo2, l0_hi2, l0_oor;
      int l1_lo, l1_hi, l1_lo2, l1_hi2;
      int exp0, exp1, exp_err, exp_oor;
   } vec_t;

   vec_t vecs[7];
   int total = 0;
   int bad = 0;

   task automatic check(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic set_windows(input vec_t v);
      lo_a[0] = v.l0_lo;  hi_a[0] = v.l0_hi;  lo_b[0] = v.l0_lo2; hi_b[0] = v.l0_hi2;
      oor_at[0] = v.l0_oor;
      lo_a[1] = v.l1_lo;  hi_a[1] = v.l1_hi;  lo_b[1] = v.l1_lo2; hi_b[1] = v.l1_hi2;
      oor_at[1] = -1;
   endtask

   task automatic pulse_rstrt();
      @(negedge SCLK) ALGN_RSTRT = 1'b1;
      @(negedge SCLK) ALGN_RSTRT = 1'b0;
      check("rstrt_clears_done", ALGN_DONE, 0);
   endtask

   task automatic wait_done(input string nm);
      bit ok = 1'b0;
      for (int i = 0; i < 20000 && !ok; i++) begin
         @(negedge SCLK);
         if (ALGN_DONE) ok = 1'b1;
      end
      check({nm, "_done_seen"}, ok, 1);
   endtask

   task automatic wait_tap(input int lane, input int tap, input string nm);
      bit ok = 1'b0;
      for (int i = 0; i < 20000 && !ok; i++) begin
         @(negedge SCLK);
         if (ALGN_START && tap_m[lane] == tap) ok = 1'b1;
      end
      check({nm, "_tap_reached"}, ok, 1);
   endtask

   task automatic check_result(input string nm, input int t0, input int t1, input int err,
                               input int oor);
      check({nm, "_tap0"}, TAPDLY[W-1:0], t0);
      check({nm, "_tap1"}, TAPDLY[2*W-1:W], t1);
      check({nm, "_iod_tap0"}, tap_m[0], t0);
      check({nm, "_iod_tap1"}, tap_m[1], t1);
      check({nm, "_lane_err"}, LANE_ERR, err);
      check({nm, "_err"}, ALGN_ERR, (err != 0) ? 1 : 0);
      check({nm, "_oor"}, ALGN_OOR, oor);
      check({nm, "_start_low"}, ALGN_START, 0);
   endtask

   initial begin
      int p0;
      vecs[0] = '{40, 79, N, N, -1,   40, 79, N, N,     60, 60, 0, 0};
      vecs[1] = '{5, 9, N, N, -1,     100, 150, N, N,   0, 125, 1, 0};
      vecs[2] = '{10, 29, 50, 69, -1, 10, 29, 50, 69,   20, 20, 0, 0};
      vecs[3] = '{20, 60, N, N, 90,   40, 79, N, N,     40, 60, 0, 1};
      vecs[4] = '{0, 255, N, N, -1,   200, 209, N, N,   127, 205, 0, 0};
      vecs[5] = '{246, 255, N, N, -1, 200, 208, N, N,   251, 0, 2, 0};
      vecs[6] = '{N, N, N, N, -1,     30, 34, 60, 63,   0, 0, 3, 0};
      set_windows(vecs[0]);

      repeat (3) @(negedge SCLK);
      RESETN = 1'b1;
      repeat (3) @(negedge SCLK);
      check("rst_pulses", {ALGN_LOAD, ALGN_MOVE, ALGN_CLR_FLGS}, 0);
      check("rst_flags", {ALGN_START, ALGN_DONE, ALGN_ERR, ALGN_OOR}, 0);
      check("rst_lane_err", LANE_ERR, 0);
      check("rst_tapdly", TAPDLY, 0);
      check("dir_inc", ALGN_DIR, 3);

      for (int v = 0; v < 7; v++) begin
         set_windows(vecs[v]);
         PLL_LOCK = 1'b1;
         pulse_rstrt();
         wait_done($sformatf("v%0d", v));
         check_result($sformatf("v%0d", v), vecs[v].exp0, vecs[v].exp1, vecs[v].exp_err,
                      vecs[v].exp_oor);
      end

      // Restart in the middle of lane 1's sweep.
      set_windows(vecs[0]);
      pulse_rstrt();
      wait_tap(1, 30, "rstrt_mid");
      pulse_rstrt();
      check("rstrt_mid_start_low", ALGN_START, 0);
      begin
         bit seen = 1'b0;
         for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge SCLK);
            if (ALGN_LOAD != '0) begin
               seen = 1'b1;
               check("rstrt_mid_load_lane0", ALGN_LOAD, 1);
            end
         end
         check("rstrt_mid_load_seen", seen, 1);
      end
      wait_done("rstrt_mid");
      check_result("rstrt_mid", 60, 60, 0, 0);

      // HOLD for 50 cycles mid-sweep freezes everything.
      pulse_rstrt();
      wait_tap(0, 50, "hold");
      ALGN_HOLD = 1'b1;
      p0 = pulse_total;
      repeat (50) @(negedge SCLK);
      check("hold_no_pulses", pulse_total - p0, 0);
      check("hold_tap_frozen", tap_m[0], 50);
      ALGN_HOLD = 1'b0;
      wait_done("hold");
      check_result("hold", 60, 60, 0, 0);

      // PLL lock lost while lane 1 sweeps, after lane 0 saw OOR.
      set_windows(vecs[3]);
      pulse_rstrt();
      wait_tap(1, 10, "pll");
      check("pll_oor_before", ALGN_OOR, 1);
      check("pll_tap0_before", TAPDLY[W-1:0], 40);
      @(negedge SCLK) PLL_LOCK = 1'b0;
      @(negedge SCLK);
      check("pll_abort_start", ALGN_START, 0);
      check("pll_abort_oor", ALGN_OOR, 0);
      check("pll_abort_tapdly", TAPDLY, 0);
      repeat (10) @(negedge SCLK);
      check("pll_stays_idle", ALGN_START, 0);
      PLL_LOCK = 1'b1;
      wait_done("pll");
      check_result("pll", 40, 60, 0, 1);

      // SKIP: DONE within two cycles, no tap moves.
      ALGN_SKIP = 1'b1;
      p0 = pulse_total;
      pulse_rstrt();
      begin
         bit ok = 1'b0;
         for (int i = 0; i < 2 && !ok; i++) begin
            @(negedge SCLK);
            if (ALGN_DONE) ok = 1'b1;
         end
         check("skip_done_fast", ok, 1);
      end
      check("skip_tapdly", TAPDLY, 0);
      check("skip_err", ALGN_ERR, 0);
      check("skip_oor", ALGN_OOR, 0);
      check("skip_no_pulses", pulse_total - p0, 0);

      // RSTRT wins over a simultaneous HOLD.
      ALGN_SKIP = 1'b0;
      PLL_LOCK  = 1'b0;
      ALGN_HOLD = 1'b1;
      pulse_rstrt();
      repeat (3) @(negedge SCLK);
      check("rstrt_hold_start", ALGN_START, 0);
      ALGN_HOLD = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
